alu_stim_gen: RTL and testbench

- Hardware stimulus generator that sits directly upstream of the ALU DUT and drives its input interface.
- Produces a programmed number of pseudo-random ALU transactions.
- Inter-transaction delays are bounded by chromosome-derived min/max settings.
- Lets GA-tuned delay ranges and the PRNG seed run in hardware rather than in the SV driver.

---
 rtl/alu_stim_gen.sv | 174 +++++++++++++++++
 tb/tb_alu_stim_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_stim_gen.sv
// Pseudo-random ALU transaction generator: LFSR-driven payloads with clamped
// inter-transaction gaps and a valid/ready handshake toward the ALU.
module alu_stim_gen #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [31:0] SEED       = 32'h1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  trans_num_i,
    input  logic [3:0]            delay_min_i,
    input  logic [3:0]            delay_max_i,
    input  logic                  alu_rdy_i,
    output logic                  act_o,
    output logic [3:0]            op_o,
    output logic [1:0]            movi_o,
    output logic [DATA_WIDTH-1:0] reg_a_o,
    output logic [DATA_WIDTH-1:0] reg_b_o,
    output logic [DATA_WIDTH-1:0] mem_o,
    output logic [DATA_WIDTH-1:0] imm_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  sent_o
);

    localparam logic [31:0] Taps     = 32'h80200003;
    localparam logic [31:0] SeedInit = (SEED == 32'h0) ? 32'h1 : SEED;

    typedef enum logic [2:0] {StIdle, StLoad, StDelay, StDrive, StFinish} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            lfsr_q, lfsr_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   trans_q, trans_d;
    logic [CNT_WIDTH-1:0]   sent_q, sent_d;
    logic [3:0]             min_q, min_d, max_q, max_d;
    logic [3:0]             op_q;
    logic [1:0]             movi_q;
    logic [DATA_WIDTH-1:0]  reg_a_q, reg_b_q, mem_q, imm_q;
    logic                   xfer;
    logic                   load_pl;
    logic [3:0]             gap;

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return {1'b0, l[31:1]} ^ (l[0] ? Taps : 32'h0);
    endfunction

    function automatic logic [3:0] clamp_gap(input logic [3:0] r, input logic [3:0] mn,
                                             input logic [3:0] mx);
        if (mn > mx) return mn;
        if (r < mn) return mn;
        if (r > mx) return mx;
        return r;
    endfunction

    // Operand k takes DATA_WIDTH successive LFSR bits starting at bit 10, wrapping mod 32.
    function automatic logic [DATA_WIDTH-1:0] field(input logic [31:0] l, input int unsigned k);
        logic [DATA_WIDTH-1:0] f;
        int unsigned           idx;
        f = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            idx  = (10 + k * DATA_WIDTH + i) % 32;
            f[i] = l[idx[4:0]];
        end
        return f;
    endfunction

    assign xfer    = (state_q == StDrive) && alu_rdy_i;
    assign gap     = clamp_gap(lfsr_q[3:0], min_q, max_q);
    assign load_pl = (state_d == StDrive) && ((state_q != StDrive) || xfer);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            lfsr_q  <= SeedInit;
            cnt_q   <= '0;
            trans_q <= '0;
            sent_q  <= '0;
            min_q   <= '0;
            max_q   <= '0;
            op_q    <= '0;
            movi_q  <= '0;
            reg_a_q <= '0;
            reg_b_q <= '0;
            mem_q   <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            trans_q <= trans_d;
            sent_q  <= sent_d;
            min_q   <= min_d;
            max_q   <= max_d;
            // Payload is sampled from the LFSR value seen in the first cycle of each drive.
            if (load_pl) begin
                op_q    <= lfsr_d[7:4];
                movi_q  <= (lfsr_d[9:8] == 2'b11) ? 2'b00 : lfsr_d[9:8];
                reg_a_q <= field(lfsr_d, 0);
                reg_b_q <= field(lfsr_d, 1);
                mem_q   <= field(lfsr_d, 2);
                imm_q   <= field(lfsr_d, 3);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = (state_q == StIdle) ? lfsr_q : lfsr_next(lfsr_q);
        cnt_d   = cnt_q;
        trans_d = trans_q;
        sent_d  = sent_q;
        min_d   = min_q;
        max_d   = max_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    trans_d = trans_num_i;
                    min_d   = delay_min_i;
                    max_d   = delay_max_i;
                    sent_d  = '0;
                    lfsr_d  = SeedInit;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (trans_q == '0) begin
                    state_d = StFinish;
                end else begin
                    cnt_d   = gap;
                    state_d = (gap == 4'd0) ? StDrive : StDelay;
                end
            end
            StDelay: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = StDrive;
            end
            StDrive: begin
                if (xfer) begin
                    sent_d = CNT_WIDTH'(sent_q + 1'b1);
                    if (sent_d == trans_q) begin
                        state_d = StFinish;
                    end else begin
                        cnt_d   = gap;
                        state_d = (gap == 4'd0) ? StDrive : StDelay;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        act_o  = 1'b0;
        done_o = 1'b0;
        busy_o = (state_q != StIdle);
        unique case (state_q)
            StDrive:  act_o  = 1'b1;
            StFinish: done_o = 1'b1;
            default:  ;
        endcase
    end

    assign op_o    = op_q;
    assign movi_o  = movi_q;
    assign reg_a_o = reg_a_q;
    assign reg_b_o = reg_b_q;
    assign mem_o   = mem_q;
    assign imm_o   = imm_q;
    assign sent_o  = sent_q;

endmodule

// File: tb/tb_alu_stim_gen.sv
// Directed bench for alu_stim_gen: cycle-exact timing of ACT/DONE/BUSY, handshake
// stalls, inverted delay bounds, async abort and payload reproducibility.
module tb_alu_stim_gen;

    localparam int unsigned DW   = 8;
    localparam int unsigned CW   = 16;
    localparam logic [31:0] Seed = 32'h1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rdy = 1'b0;
    logic [CW-1:0] trans_num = '0;
    logic [3:0]    dmin = '0;
    logic [3:0]    dmax = '0;
    logic          act, busy, done;
    logic [3:0]    op;
    logic [1:0]    movi;
    logic [DW-1:0] reg_a, reg_b, mem, imm;
    logic [CW-1:0] sent;
    logic [63:0]   obs_pl;

    int n_checks = 0;
    int n_fail   = 0;
    int movi3    = 0;

    always #5 clk = ~clk;

    alu_stim_gen #(.DATA_WIDTH(DW), .SEED(Seed), .CNT_WIDTH(CW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .trans_num_i (trans_num),
        .delay_min_i (dmin),
        .delay_max_i (dmax),
        .alu_rdy_i   (rdy),
        .act_o       (act),
        .op_o        (op),
        .movi_o      (movi),
        .reg_a_o     (reg_a),
        .reg_b_o     (reg_b),
        .mem_o       (mem),
        .imm_o       (imm),
        .busy_o      (busy),
        .done_o      (done),
        .sent_o      (sent)
    );

    assign obs_pl = 64'({op, movi, reg_a, reg_b, mem, imm});

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {1'b0, l[31:1]} ^ (l[0] ? 32'h80200003 : 32'h0);
    endfunction

    // LFSR holds Seed in cycle 1 of a run and advances once per cycle after that.
    function automatic logic [31:0] lfsr_at(input int c);
        logic [31:0] l;
        l = Seed;
        for (int i = 1; i < c; i++) l = lfsr_step(l);
        return l;
    endfunction

    function automatic logic [63:0] exp_pl(input logic [31:0] l);
        logic [3:0]    o;
        logic [1:0]    mv;
        logic [DW-1:0] f [4];
        o  = l[7:4];
        mv = (l[9:8] == 2'b11) ? 2'b00 : l[9:8];
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < int'(DW); i++) f[k][i] = l[(10 + k * DW + i) % 32];
        return 64'({o, mv, f[0], f[1], f[2], f[3]});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 0; returns in cycle 1.
    task automatic start_run(input logic [CW-1:0] n, input logic [3:0] mn, input logic [3:0] mx);
        trans_num = n;
        dmin      = mn;
        dmax      = mx;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    initial begin
        #1;
        check_eq("rst act", act, 0);
        check_eq("rst busy", busy, 0);
        check_eq("rst done", done, 0);
        check_eq("rst sent", sent, 0);
        check_eq("rst payload", obs_pl, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Zero-length run
        start_run(0, 0, 0);
        check_eq("t1 busy c1", busy, 1);
        check_eq("t1 done c1", done, 0);
        step();
        check_eq("t1 done c2", done, 1);
        check_eq("t1 busy c2", busy, 1);
        check_eq("t1 act c2", act, 0);
        step();
        check_eq("t1 busy c3", busy, 0);
        check_eq("t1 done c3", done, 0);
        check_eq("t1 sent", sent, 0);

        // Back-to-back transfers, zero gap
        rdy = 1'b1;
        start_run(5, 0, 0);
        for (int c = 1; c <= 8; c++) begin
            check_eq($sformatf("t2 act c%0d", c), act, (c >= 2 && c <= 6));
            check_eq($sformatf("t2 done c%0d", c), done, (c == 7));
            if (act) begin
                check_eq($sformatf("t2 payload c%0d", c), obs_pl, exp_pl(lfsr_at(c)));
                if (movi == 2'd3) movi3++;
            end
            if (c == 2) check_eq("t2 hand payload c2", obs_pl,
                                 64'({4'h0, 2'h0, 8'h00, 8'h08, 8'hE0, 8'h00}));
            if (c == 3) check_eq("t2 hand payload c3", obs_pl,
                                 64'({4'h0, 2'h0, 8'h00, 8'h0C, 8'hB0, 8'h00}));
            step();
        end
        check_eq("t2 sent", sent, 5);
        check_eq("t2 movi never 3", movi3, 0);

        // Fixed gap of 3
        start_run(3, 3, 3);
        for (int c = 1; c <= 15; c++) begin
            check_eq($sformatf("t3 act c%0d", c), act, (c == 5 || c == 9 || c == 13));
            check_eq($sformatf("t3 done c%0d", c), done, (c == 14));
            step();
        end
        check_eq("t3 sent", sent, 3);

        // Handshake stall: ready low for the first 4 ACT cycles
        rdy = 1'b0;
        start_run(2, 0, 0);
        step();
        for (int c = 2; c <= 5; c++) begin
            check_eq($sformatf("t4 act c%0d", c), act, 1);
            check_eq($sformatf("t4 hold c%0d", c), obs_pl,
                     64'({4'h0, 2'h0, 8'h00, 8'h08, 8'hE0, 8'h00}));
            check_eq($sformatf("t4 sent c%0d", c), sent, 0);
            step();
        end
        rdy = 1'b1;
        check_eq("t4 act c6", act, 1);
        check_eq("t4 hold c6", obs_pl, 64'({4'h0, 2'h0, 8'h00, 8'h08, 8'hE0, 8'h00}));
        step();
        check_eq("t4 sent c7", sent, 1);
        check_eq("t4 act c7", act, 1);
        check_eq("t4 payload c7", obs_pl, exp_pl(lfsr_at(7)));
        step();
        check_eq("t4 done c8", done, 1);
        check_eq("t4 sent c8", sent, 2);
        step();

        // Inverted bounds use the minimum; START mid-run is ignored
        start_run(4, 6, 2);
        for (int c = 1; c <= 31; c++) begin
            check_eq($sformatf("t5 act c%0d", c), act, (c == 8 || c == 15 || c == 22 || c == 29));
            check_eq($sformatf("t5 done c%0d", c), done, (c == 30));
            start = (c == 10);
            step();
        end
        start = 1'b0;
        check_eq("t5 sent", sent, 4);
        check_eq("t5 busy", busy, 0);

        // Async abort during transaction 2, then reproducible rerun
        start_run(4, 0, 0);
        step();
        step();
        check_eq("t6 act pre", act, 1);
        check_eq("t6 sent pre", sent, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6 act abort", act, 0);
        check_eq("t6 busy abort", busy, 0);
        check_eq("t6 sent abort", sent, 0);
        check_eq("t6 done abort", done, 0);
        step();
        check_eq("t6 done held", done, 0);
        #2 rst_n = 1'b1;
        step();
        start_run(4, 0, 0);
        for (int c = 1; c <= 6; c++) begin
            check_eq($sformatf("t6 act c%0d", c), act, (c >= 2 && c <= 5));
            check_eq($sformatf("t6 done c%0d", c), done, (c == 6));
            if (c >= 2 && c <= 5)
                check_eq($sformatf("t6 payload c%0d", c), obs_pl, exp_pl(lfsr_at(c)));
            step();
        end
        check_eq("t6 sent", sent, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
